// File: rtl/uart_rx_deserializer.sv
// UART receive frame engine: oversampled start detection, LSB-first deserialisation,
// optional parity and 1/2 stop bits, one-entry holding register with pop handshake.
module uart_rx_deserializer #(
    parameter int WIDTH       = 8,
    parameter int SAMPLE_RATE = 16,
    parameter bit USE_PARITY  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_parity,
    input  logic [1:0]       cfg_stop_bits,
    input  logic [15:0]      cfg_clk_div,
    input  logic             uart_rx,
    input  logic             rx_req,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             busy
);
    localparam int SW = $clog2(SAMPLE_RATE);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t             state_q, state_d;
    logic               meta_q, rxs_q;
    logic [15:0]        div_cnt_q, div_cnt_d, div_m1;
    logic [SW-1:0]      scnt_q, scnt_d, scnt_tgt;
    logic [BW-1:0]      bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               perr_q, perr_d, ferr_q, ferr_d;
    logic               stop2_q, stop2_d, armed_q, armed_d;
    logic [1:0]         par_q, par_d;
    logic               two_stop_q, two_stop_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               rx_ready_q, rx_ready_d, parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
    logic               tick, smp, start_go, par_en, commit, pop;

    always_comb begin
        div_m1    = (cfg_clk_div == 16'd0) ? 16'd0 : cfg_clk_div - 16'd1;
        tick      = (div_cnt_q >= div_m1);
        // armed_q blocks re-triggering on a line that is still low after a commit (break)
        start_go  = (state_q == S_IDLE) && armed_q && !rxs_q;
        div_cnt_d = (start_go || tick) ? 16'd0 : div_cnt_q + 16'd1;
        scnt_tgt  = (state_q == S_START) ? SW'(SAMPLE_RATE / 2 - 1) : SW'(SAMPLE_RATE - 1);
        smp       = tick && (scnt_q == scnt_tgt) && (state_q != S_IDLE);
        if (state_q == S_IDLE) scnt_d = '0;
        else if (tick)         scnt_d = smp ? '0 : scnt_q + SW'(1);
        else                   scnt_d = scnt_q;
        par_en    = USE_PARITY && ((par_q == 2'd1) || (par_q == 2'd2));
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop2_d    = stop2_q;
        armed_d    = armed_q;
        par_d      = par_q;
        two_stop_d = two_stop_q;
        commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rxs_q) armed_d = 1'b1;
                if (start_go) begin
                    state_d    = S_START;
                    par_d      = cfg_parity;
                    two_stop_d = (cfg_stop_bits != 2'd0);
                    bitcnt_d   = '0;
                    data_d     = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop2_d    = 1'b0;
                end
            end
            S_START: if (smp) state_d = rxs_q ? S_IDLE : S_DATA;
            S_DATA: if (smp) begin
                data_d[bitcnt_q] = rxs_q;
                if (bitcnt_q == BW'(WIDTH - 1)) state_d = par_en ? S_PARITY : S_STOP;
                else                            bitcnt_d = bitcnt_q + BW'(1);
            end
            S_PARITY: if (smp) begin
                perr_d  = (^data_q) ^ rxs_q ^ (par_q == 2'd1);
                state_d = S_STOP;
            end
            S_STOP: if (smp) begin
                ferr_d = ferr_q | !rxs_q;
                if (two_stop_q && !stop2_q) begin
                    stop2_d = 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                    armed_d = rxs_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pop           = rx_req && rx_ready_q;
        rx_data_d     = commit ? data_q : rx_data_q;
        parity_err_d  = commit ? perr_q : parity_err_q;
        frame_err_d   = commit ? ferr_d : frame_err_q;
        rx_ready_d    = commit | (rx_ready_q & !pop);
        overrun_err_d = commit ? (rx_ready_q & !pop) : (overrun_err_q & !pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q        <= 1'b1;
            rxs_q         <= 1'b1;
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            scnt_q        <= '0;
            bitcnt_q      <= '0;
            data_q        <= '0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            stop2_q       <= 1'b0;
            armed_q       <= 1'b1;
            par_q         <= '0;
            two_stop_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_ready_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            meta_q        <= uart_rx;
            rxs_q         <= meta_q;
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            scnt_q        <= scnt_d;
            bitcnt_q      <= bitcnt_d;
            data_q        <= data_d;
            perr_q        <= perr_d;
            ferr_q        <= ferr_d;
            stop2_q       <= stop2_d;
            armed_q       <= armed_d;
            par_q         <= par_d;
            two_stop_q    <= two_stop_d;
            rx_data_q     <= rx_data_d;
            rx_ready_q    <= rx_ready_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_ready    = rx_ready_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: serial stimulus pushes expected frames into a
// scoreboard; a monitor pops and compares each time busy drops (frame end or false start).
module tb_uart_rx_deserializer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cfg_parity = 2'd0;
    logic [1:0]  cfg_stop_bits = 2'd0;
    logic [15:0] cfg_clk_div = 16'd54;
    logic        uart_rx = 1'b1;
    logic        rx_req = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_ready, parity_err, frame_err, overrun_err, busy;

    uart_rx_deserializer #(.WIDTH(8), .SAMPLE_RATE(16), .USE_PARITY(1)) dut (
        .clk(clk), .rst(rst), .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits),
        .cfg_clk_div(cfg_clk_div), .uart_rx(uart_rx), .rx_req(rx_req), .rx_data(rx_data),
        .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       frame;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       oerr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   bitp  = 864;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic fr, input logic [7:0] d, input logic pe, input logic fe,
                        input logic oe);
        exp_t e;
        e.frame = fr; e.data = d; e.perr = pe; e.ferr = fe; e.oerr = oe;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && busy_prev && !busy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got data 0x%0h ready %0b expected none at %0t",
                         rx_data, rx_ready, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx_ready", 32'(rx_ready), 32'(e.frame));
                if (e.frame) begin
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                    check("frame_err", 32'(frame_err), 32'(e.ferr));
                end
                check("overrun_err", 32'(overrun_err), 32'(e.oerr));
            end
        end
        busy_prev <= busy;
    end

    task automatic set_div(input int d);
        cfg_clk_div = 16'(d);
        bitp = 16 * ((d == 0) ? 1 : d);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par, input bit pbit,
                              input int nstop, input bit stop2_val);
        uart_rx = 1'b0;
        repeat (bitp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (bitp) @(negedge clk);
        end
        if (use_par) begin
            uart_rx = pbit;
            repeat (bitp) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (bitp) @(negedge clk);
        if (nstop == 2) begin
            uart_rx = stop2_val;
            repeat (bitp) @(negedge clk);
            uart_rx = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_pop(input logic [7:0] hold);
        rx_req = 1'b1;
        @(negedge clk);
        rx_req = 1'b0;
        check("pop_ready", 32'(rx_ready), 32'd0);
        check("pop_overrun", 32'(overrun_err), 32'd0);
        check("pop_data_hold", 32'(rx_data), 32'(hold));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Plain 8N1 frame
        set_div(54);
        push(1, 8'hA5, 0, 0, 0);
        send_frame(8'hA5, 0, 0, 1, 1);
        do_pop(8'hA5);

        // Parity: even good, even with bit 7 flipped, odd good (at clk_div 0 == 1)
        set_div(8);
        cfg_parity = 2'd2;
        push(1, 8'h03, 0, 0, 0);
        send_frame(8'h03, 1, 0, 1, 1);
        do_pop(8'h03);
        push(1, 8'h83, 1, 0, 0);
        send_frame(8'h83, 1, 0, 1, 1);
        do_pop(8'h83);
        cfg_parity = 2'd1;
        set_div(0);
        push(1, 8'h00, 0, 0, 0);
        send_frame(8'h00, 1, 1, 1, 1);
        do_pop(8'h00);

        // Short low glitch is rejected as a false start, then a real frame
        set_div(54);
        cfg_parity = 2'd0;
        push(0, 8'h00, 0, 0, 0);
        uart_rx = 1'b0;
        repeat (162) @(negedge clk);
        uart_rx = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_busy_idle", 32'(busy), 32'd0);
        check("glitch_no_ready", 32'(rx_ready), 32'd0);
        push(1, 8'h5A, 0, 0, 0);
        send_frame(8'h5A, 0, 0, 1, 1);
        do_pop(8'h5A);

        // Two stop bits, second one low, then a clean frame
        set_div(8);
        cfg_stop_bits = 2'd1;
        push(1, 8'h3C, 0, 1, 0);
        send_frame(8'h3C, 0, 0, 2, 0);
        do_pop(8'h3C);
        push(1, 8'hC3, 0, 0, 0);
        send_frame(8'hC3, 0, 0, 2, 1);
        do_pop(8'hC3);
        cfg_stop_bits = 2'd0;

        // Back-to-back overrun; third commit coincides with a pop
        set_div(54);
        push(1, 8'h11, 0, 0, 0);
        push(1, 8'h22, 0, 0, 1);
        push(1, 8'h33, 0, 0, 0);
        send_frame(8'h11, 0, 0, 1, 1);
        send_frame(8'h22, 0, 0, 1, 1);
        fork
            send_frame(8'h33, 0, 0, 1, 1);
            begin
                // commit edge is 3 + (16*9 + 8) * 54 edges after the start bit is driven
                repeat (2 + 152 * 54) @(negedge clk);
                rx_req = 1'b1;
                @(negedge clk);
                rx_req = 1'b0;
            end
        join
        check("coincident_ready", 32'(rx_ready), 32'd1);
        do_pop(8'h33);

        // Reset in the middle of data bit 4
        set_div(8);
        uart_rx = 1'b0;
        repeat (bitp) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'b0;
            repeat (bitp) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (bitp / 2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        check("mid_rst_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        push(1, 8'h96, 0, 0, 0);
        send_frame(8'h96, 0, 0, 1, 1);
        do_pop(8'h96);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
